// File: rtl/scan_ctrl.sv
// Scan-chain controller: loads a pattern, shifts it LSB-first through the
// register chain while capturing the bits that fall out, then hands them back.
module scan_ctrl #(
  parameter int CHAIN_LEN = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic                 abort,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [CHAIN_LEN-1:0] result_out,
  output logic                 busy,
  output logic                 test,
  output logic                 scan_in,
  input  logic                 scan_out
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CHAIN_LEN-1:0] sh;
  logic [CNT_W-1:0]     cnt;
  logic                 accept;
  logic                 last_shift;

  assign accept     = start_valid && (state_q == IDLE);
  assign last_shift = (cnt == CNT_W'(CHAIN_LEN - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort outranks the final shift edge, so an aborted run never reaches DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = SHIFT;
      SHIFT: begin
        if (abort)           state_d = IDLE;
        else if (last_shift) state_d = DONE;
      end
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The shift register doubles as the capture register: chain bits enter at
  // the MSB and after CHAIN_LEN shifts the first one out sits at bit 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sh  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sh  <= pattern_in;
      cnt <= '0;
    end else if (state_q == SHIFT) begin
      sh  <= {scan_out, sh[CHAIN_LEN-1:1]};
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    start_ready  = 1'b0;
    busy         = 1'b1;
    test         = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      SHIFT:   test         = 1'b1;
      DONE:    result_valid = 1'b1;
      default: begin
        start_ready = 1'b0;
        busy        = 1'b1;
      end
    endcase
  end

  assign scan_in    = sh[0];
  assign result_out = sh;

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl: loopback and register-chain models on the
// serial side, with hand-computed expectations per scenario.
module tb_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] pattern_in = '0;
  logic        abort = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] result_out;
  logic        busy;
  logic        test;
  logic        scan_in;
  logic        scan_out;

  logic        loop_mode = 1'b1;
  logic        chain_load = 1'b0;
  logic [31:0] chain_init = '0;
  logic [31:0] chain;

  int n_checks = 0;
  int n_fail   = 0;

  scan_ctrl #(.CHAIN_LEN(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .pattern_in   (pattern_in),
    .abort        (abort),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_out   (result_out),
    .busy         (busy),
    .test         (test),
    .scan_in      (scan_in),
    .scan_out     (scan_out)
  );

  always #5 clock = ~clock;

  // External register chain: shifts scan_in in at the MSB while test is high.
  always @(posedge clock) begin
    if (chain_load)
      chain <= chain_init;
    else if (test)
      chain <= {scan_in, chain[31:1]};
  end

  assign scan_out = loop_mode ? scan_in : chain[0];

  // Called at a negedge in IDLE; returns at the negedge of cycle 1.
  task automatic start_op(input logic [31:0] pat);
    start_valid = 1'b1;
    pattern_in  = pat;
    @(negedge clock);
    start_valid = 1'b0;
    pattern_in  = ~pat;
  endtask

  // Counts cycles from cycle 1 until result_valid, bounded at 60 cycles.
  task automatic wait_result(output int first_rv, output int tcnt);
    first_rv = 0;
    tcnt     = 0;
    for (int n = 1; n <= 60; n++) begin
      if (result_valid) begin
        first_rv = n;
        break;
      end
      if (test) tcnt++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({start_ready, test, scan_in, result_valid, busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy/test/sin/rv/busy=%b want 10000",
               {start_ready, test, scan_in, result_valid, busy});
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_loopback();
    int first_rv, tcnt;
    loop_mode = 1'b1;
    start_op(32'hA5C30F81);
    n_checks++;
    if (test !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL loop_test_rise: test=%b busy=%b want 1 1", test, busy);
    end
    wait_result(first_rv, tcnt);
    n_checks++;
    if (first_rv !== 33) begin
      n_fail++;
      $display("FAIL loop_latency: result_valid at cycle %0d want 33", first_rv);
    end
    n_checks++;
    if (tcnt !== 32) begin
      n_fail++;
      $display("FAIL loop_test_len: test high %0d cycles want 32", tcnt);
    end
    n_checks++;
    if (result_out !== 32'hA5C30F81) begin
      n_fail++;
      $display("FAIL loop_data: got %h want a5c30f81", result_out);
    end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    n_checks++;
    if ({start_ready, busy, result_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL loop_release: rdy/busy/rv=%b want 100",
               {start_ready, busy, result_valid});
    end
  endtask

  task automatic test_chain_backpressure();
    int first_rv, tcnt;
    loop_mode  = 1'b0;
    chain_init = 32'h12345678;
    chain_load = 1'b1;
    @(negedge clock);
    chain_load = 1'b0;
    start_op(32'hDEADBEEF);
    wait_result(first_rv, tcnt);
    n_checks++;
    if (first_rv !== 33 || result_out !== 32'h12345678) begin
      n_fail++;
      $display("FAIL chain_data: got %h at cycle %0d want 12345678 at 33",
               result_out, first_rv);
    end
    n_checks++;
    if (chain !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL chain_model: got %h want deadbeef", chain);
    end
    // Hold result under backpressure while a new request and abort are offered.
    start_valid = 1'b1;
    pattern_in  = 32'hFFFFFFFF;
    abort       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++;
      if ({result_valid, start_ready, test, busy} !== 4'b1001 ||
          result_out !== 32'h12345678) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: rv/rdy/test/busy=%b data=%h want 1001 12345678",
                 i, {result_valid, start_ready, test, busy}, result_out);
      end
    end
    start_valid  = 1'b0;
    abort        = 1'b0;
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    n_checks++;
    if ({start_ready, busy, result_valid, test} !== 4'b1000 ||
        chain !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bp_release: rdy/busy/rv/test=%b chain=%h want 1000 deadbeef",
               {start_ready, busy, result_valid, test}, chain);
    end
  endtask

  task automatic test_abort();
    int first_rv, tcnt;
    int seen_rv;
    loop_mode = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    n_checks++;
    if ({start_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_idle: rdy/busy=%b want 10", {start_ready, busy});
    end
    start_op(32'h0000FFFF);
    repeat (4) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    n_checks++;
    if ({test, start_ready, busy, result_valid} !== 4'b0100) begin
      n_fail++;
      $display("FAIL abort_exit: test/rdy/busy/rv=%b want 0100",
               {test, start_ready, busy, result_valid});
    end
    seen_rv = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) seen_rv++;
      @(negedge clock);
    end
    n_checks++;
    if (seen_rv !== 0) begin
      n_fail++;
      $display("FAIL abort_no_result: result_valid seen %0d cycles want 0", seen_rv);
    end
    start_op(32'h13579BDF);
    wait_result(first_rv, tcnt);
    n_checks++;
    if (first_rv !== 33 || tcnt !== 32 || result_out !== 32'h13579BDF) begin
      n_fail++;
      $display("FAIL abort_fresh: data=%h cycle=%0d test=%0d want 13579bdf 33 32",
               result_out, first_rv, tcnt);
    end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int first_rv, tcnt;
    loop_mode = 1'b1;
    start_op(32'h80000001);
    wait_result(first_rv, tcnt);
    n_checks++;
    if (first_rv !== 33 || result_out !== 32'h80000001) begin
      n_fail++;
      $display("FAIL b2b_first: data=%h cycle=%0d want 80000001 33", result_out, first_rv);
    end
    // Request offered in the handshake cycle must wait for the following edge.
    result_ready = 1'b1;
    start_valid  = 1'b1;
    pattern_in   = 32'h7FFFFFFE;
    @(negedge clock);
    result_ready = 1'b0;
    n_checks++;
    if ({start_ready, test, result_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_gap: rdy/test/rv=%b want 100", {start_ready, test, result_valid});
    end
    @(negedge clock);
    start_valid = 1'b0;
    pattern_in  = 32'h0;
    n_checks++;
    if ({start_ready, test} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_accept: rdy/test=%b want 01", {start_ready, test});
    end
    wait_result(first_rv, tcnt);
    n_checks++;
    if (first_rv !== 33 || result_out !== 32'h7FFFFFFE) begin
      n_fail++;
      $display("FAIL b2b_second: data=%h cycle=%0d want 7ffffffe 33", result_out, first_rv);
    end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int seen_rv;
    loop_mode = 1'b1;
    start_op(32'hCAFEF00D);
    repeat (19) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    n_checks++;
    if ({start_ready, test, scan_in, result_valid, busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL midreset_outputs: rdy/test/sin/rv/busy=%b want 10000",
               {start_ready, test, scan_in, result_valid, busy});
    end
    seen_rv = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid || test) seen_rv++;
      @(negedge clock);
    end
    n_checks++;
    if (seen_rv !== 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: activity seen %0d cycles want 0", seen_rv);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_loopback();
    test_chain_backpressure();
    test_abort();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 32, giving the scan chain length in bits (4 registers x 8 bits).
REQ-002 The block SHALL have these ports, as name, direction, width, meaning:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start_valid  input  1  host requests a scan operation.
- start_ready  output  1  controller can accept a request.
- pattern_in  input  CHAIN_LEN  pattern to shift into the chain.
- abort  input  1  cancels an operation in progress.
- result_valid  output  1  captured chain contents are available.
- result_ready  input  1  host accepts the result.
- result_out  output  CHAIN_LEN  captured chain contents.
- busy  output  1  high in any state other than IDLE.
- test  output  1  scan-enable to the register file.
- scan_in  output  1  serial data to the chain.
- scan_out  input  1  serial data from the chain end.

Function
REQ-003 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-004 The block SHALL drive start_ready=1 only in IDLE; a request SHALL be accepted on a rising edge where start_valid=1 and start_ready=1.
REQ-005 On acceptance the block SHALL load pattern_in into a CHAIN_LEN-bit shift register sh, clear the bit counter, and enter SHIFT; later changes to pattern_in SHALL have no effect.
REQ-006 The block SHALL drive test=1 only while in SHIFT, decoded from the state register.
REQ-007 The block SHALL drive scan_in=sh[0] at all times.
REQ-008 On each edge in SHIFT, the block SHALL update sh to {scan_out, sh[CHAIN_LEN-1:1]} and increment the counter; the pattern is therefore sent LSB first.
REQ-009 SHIFT SHALL last exactly CHAIN_LEN cycles; on the edge that completes shift CHAIN_LEN the FSM SHALL enter DONE.
REQ-010 Shift-cycle timing:
- test SHALL first be high in the cycle after acceptance.
- result_valid SHALL first be high CHAIN_LEN+1 cycles after acceptance.
REQ-011 In DONE the block SHALL hold result_valid=1 and result_out=sh stable until an edge with result_ready=1, then return to IDLE.
REQ-012 In IDLE and SHIFT, result_valid SHALL be 0; in those states result_out is don't-care.
REQ-013 Bit i of result_out SHALL equal the i-th bit to exit the chain, which is chain bit i before the operation.
REQ-014 The counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL NOT wrap during an operation.
REQ-015 abort=1 on an edge in SHIFT SHALL send the FSM to IDLE: test=0 next cycle, no result produced, and the chain is left partially shifted.
REQ-016 abort SHALL be ignored in IDLE and DONE.
REQ-017 abort on the final shift edge SHALL take priority over entering DONE.
REQ-018 start_valid in SHIFT or DONE SHALL be ignored and not queued; in the result handshake cycle a new request can be accepted no earlier than the following edge.
REQ-019 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.

Reset
REQ-020 reset=0 on a rising edge SHALL force:
- FSM to IDLE;
- sh and counter to 0;
- test=0, scan_in=0, result_valid=0, busy=0, start_ready=1.
REQ-021 Reset SHALL take priority over every other input, including mid-SHIFT; an interrupted operation SHALL produce no result.

Verification
REQ-022 Reset: hold reset=0 for 2 cycles -> start_ready=1, test=0, scan_in=0, result_valid=0, busy=0.
REQ-023 Loopback, scan_out tied to scan_in: pattern 0xA5C30F81 -> test high exactly 32 cycles, result_out=0xA5C30F81, result_valid first high 33 cycles after acceptance.
REQ-024 Chain model (32-bit register, shifts scan_in in at MSB, scan_out=bit0 while test=1), preloaded 0x12345678: pattern 0xDEADBEEF -> result_out=0x12345678 and model holds 0xDEADBEEF.
REQ-025 Backpressure: result_ready=0 for 10 cycles with start_valid=1 -> result_valid stays 1, result_out stable, start_ready=0, no new operation; then result_ready=1 -> IDLE next cycle.
REQ-026 Abort: abort=1 on shift edge 5 -> test=0 next cycle, result_valid never asserts, start_ready=1; a fresh request then completes normally.
REQ-027 Mid-shift reset: reset=0 at shift cycle 20 -> all outputs at reset values next cycle and no result_valid pulse.
